// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM states, S-box and Rcon lookups.
package aes_pkg;

   localparam logic [3:0] NR = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_EXPAND = 2'b01,
      ST_OUTPUT = 2'b10
   } state_t;

   // Element 0 sits in the most significant byte, so SBOX[x] is a direct lookup.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/inv_key_sched_if.sv
// Request/response bundle between the decrypt round datapath and inv_key_sched.
interface inv_key_sched_if;
   logic         i_Start;
   logic [127:0] i_Key;
   logic         i_Next;
   logic         o_Busy;
   logic         o_RKeyVld;
   logic [127:0] o_RKey;
   logic [3:0]   o_Round;
   logic         o_Last;

   modport master (output i_Start, i_Key, i_Next,
                   input  o_Busy, o_RKeyVld, o_RKey, o_Round, o_Last);
   modport slave  (input  i_Start, i_Key, i_Next,
                   output o_Busy, o_RKeyVld, o_RKey, o_Round, o_Last);
endinterface

// File: rtl/MixCol_Top.sv
// (Inv)MixColumns over a 128-bit state; built only when INV_KEY_EQUIV_EN is defined.
`ifdef INV_KEY_EQUIV_EN
module MixCol_Top (
   input  logic         i_fDec,
   input  logic [127:0] i_Data,
   output logic [127:0] o_Data
);
   logic [3:0][3:0] w_Coef;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Output row r uses coefficient (j - r) mod 4 against input row j (circulant matrix).
   function automatic logic [7:0] mixbyte(input logic [0:3][7:0] col, input logic [1:0] r,
                                          input logic [3:0][3:0] cf);
      logic [7:0] acc;
      logic [1:0] k;
      acc = '0;
      for (int j = 0; j < 4; j++) begin
         k = 2'(j) - r;
         acc ^= gmul(col[j], cf[k]);
      end
      return acc;
   endfunction

   assign w_Coef = i_fDec ? {4'h9, 4'hd, 4'hb, 4'he} : {4'h1, 4'h1, 4'h3, 4'h2};

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign o_Data[127-32*c-8*r -: 8] = mixbyte(i_Data[127-32*c -: 32], 2'(r), w_Coef);
      end
   end
endmodule
`endif

// File: rtl/key_subword.sv
// SubWord(RotWord(w)): one S-box per byte lane after a one-byte left rotate.
module key_subword
   import aes_pkg::*;
(
   input  logic [31:0] i_Word,
   output logic [31:0] o_Word
);
   logic [31:0] w_Rot;

   assign w_Rot = {i_Word[23:0], i_Word[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sb
      assign o_Word[8*g +: 8] = sbox(w_Rot[8*g +: 8]);
   end
endmodule

// File: rtl/inv_key_sched.sv
// AES-128 decryption key scheduler: expand to round 10, then walk the recurrence back to 0.
// Define INV_KEY_EQUIV_EN to present rounds 1..9 in equivalent-inverse-cipher form.
module inv_key_sched
   import aes_pkg::*;
(
   input  logic           i_Clk,
   input  logic           i_Rst_n,
   inv_key_sched_if.slave io_Kif
);
   state_t       r_State, w_NxtState;
   logic [127:0] r_Key;
   logic [3:0]   r_Round;
   logic [31:0]  w_A0, w_A1, w_A2, w_A3, w_B3, w_W0, w_W1, w_W2;
   logic [31:0]  w_SubIn, w_SubOut, w_Rcon;
   logic         w_Rev, w_Load;

   assign {w_A0, w_A1, w_A2, w_A3} = r_Key;
   assign w_Rev  = (r_State == ST_OUTPUT);
   assign w_Load = io_Kif.i_Start && (r_State != ST_EXPAND);

   // One S-box word serves both directions: forward rotates w3, reverse rotates w3^w2.
   assign w_B3    = w_A3 ^ w_A2;
   assign w_SubIn = w_Rev ? w_B3 : w_A3;
   assign w_Rcon  = {rcon(w_Rev ? r_Round : r_Round + 4'd1), 24'h0};

   key_subword u_sub (.i_Word(w_SubIn), .o_Word(w_SubOut));

   assign w_W0 = w_A0 ^ w_SubOut ^ w_Rcon;
   assign w_W1 = w_A1 ^ w_W0;
   assign w_W2 = w_A2 ^ w_W1;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) r_State <= ST_IDLE;
      else          r_State <= w_NxtState;
   end

   always_comb begin
      w_NxtState = r_State;
      case (r_State)
         ST_IDLE:   if (io_Kif.i_Start) w_NxtState = ST_EXPAND;
         ST_EXPAND: if (r_Round == NR - 4'd1) w_NxtState = ST_OUTPUT;
         ST_OUTPUT: begin
            if (io_Kif.i_Start) w_NxtState = ST_EXPAND;
            else if (io_Kif.i_Next && r_Round == 4'd0) w_NxtState = ST_IDLE;
         end
         default:   w_NxtState = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Key   <= '0;
         r_Round <= '0;
      end else if (w_Load) begin
         r_Key   <= io_Kif.i_Key;
         r_Round <= '0;
      end else if (r_State == ST_EXPAND) begin
         r_Key   <= {w_W0, w_W1, w_W2, w_A3 ^ w_W2};
         r_Round <= r_Round + 4'd1;
      end else if (w_Rev && io_Kif.i_Next && r_Round != 4'd0) begin
         r_Key   <= {w_W0, w_A1 ^ w_A0, w_A2 ^ w_A1, w_B3};
         r_Round <= r_Round - 4'd1;
      end
   end

   always_comb begin
      io_Kif.o_Busy    = (r_State == ST_EXPAND);
      io_Kif.o_RKeyVld = w_Rev;
      io_Kif.o_Last    = w_Rev && (r_Round == 4'd0);
   end

   assign io_Kif.o_Round = r_Round;

`ifdef INV_KEY_EQUIV_EN
   logic [127:0] w_MixKey;

   MixCol_Top u_imc (.i_fDec(1'b1), .i_Data(r_Key), .o_Data(w_MixKey));

   assign io_Kif.o_RKey = (r_Round != 4'd0 && r_Round != NR) ? w_MixKey : r_Key;
`else
   assign io_Kif.o_RKey = r_Key;
`endif
endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched: FIPS-197 key vectors, handshake corners, async reset.
module tb_inv_key_sched;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

   typedef struct {
      logic [3:0]   round;
      logic [127:0] rkey;
      logic         last;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_pass = 0;
   int   n_tot  = 0;
   vec_t tbl [11];
   logic [127:0] k2_key [11];
   logic         k2_known [11];

   inv_key_sched_if kif ();

   inv_key_sched dut (.i_Clk(clk), .i_Rst_n(rst_n), .io_Kif(kif));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

`ifdef INV_KEY_EQUIV_EN
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] inv_mc(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a [4];
      logic [7:0] a2 [4];
      logic [7:0] a4 [4];
      logic [7:0] a8 [4];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            a[r]  = s[127-32*c-8*r -: 8];
            a2[r] = xt(a[r]);
            a4[r] = xt(a2[r]);
            a8[r] = xt(a4[r]);
         end
         for (int r = 0; r < 4; r++) begin
            // 0e*x ^ 0b*y ^ 0d*z ^ 09*w with rows rotated by r
            o[127-32*c-8*r -: 8] = (a8[r] ^ a4[r] ^ a2[r])
                                 ^ (a8[(r+1)%4] ^ a2[(r+1)%4] ^ a[(r+1)%4])
                                 ^ (a8[(r+2)%4] ^ a4[(r+2)%4] ^ a[(r+2)%4])
                                 ^ (a8[(r+3)%4] ^ a[(r+3)%4]);
         end
      end
      return o;
   endfunction
`endif

   function automatic logic [127:0] exp_key(input logic [127:0] raw, input logic [3:0] r);
`ifdef INV_KEY_EQUIV_EN
      if (r != 4'd0 && r != 4'd10) return inv_mc(raw);
`endif
      return raw;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  128'(kif.o_Busy),    128'd0);
      chk({tag, "_vld"},   128'(kif.o_RKeyVld), 128'd0);
      chk({tag, "_rkey"},  kif.o_RKey,          128'd0);
      chk({tag, "_round"}, 128'(kif.o_Round),   128'd0);
      chk({tag, "_last"},  128'(kif.o_Last),    128'd0);
   endtask

   task automatic start_key(input logic [127:0] k);
      @(negedge clk);
      kif.i_Start = 1'b1;
      kif.i_Key   = k;
      @(negedge clk);
      kif.i_Start = 1'b0;
   endtask

   // cyc counts negedges after the start edge; first valid key expected at 11.
   task automatic wait_vld(input int cyc0, output int cyc, output int bcnt);
      cyc  = cyc0;
      bcnt = 0;
      while (kif.o_RKeyVld !== 1'b1 && cyc < 40) begin
         if (kif.o_Busy === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("%s_r%0d_vld", tag, tbl[i].round),   128'(kif.o_RKeyVld), 128'd1);
         chk($sformatf("%s_r%0d_round", tag, tbl[i].round), 128'(kif.o_Round), 128'(tbl[i].round));
         chk($sformatf("%s_r%0d_key", tag, tbl[i].round),   kif.o_RKey,
             exp_key(tbl[i].rkey, tbl[i].round));
         chk($sformatf("%s_r%0d_last", tag, tbl[i].round),  128'(kif.o_Last), 128'(tbl[i].last));
         kif.i_Next = 1'b1;
         @(negedge clk);
      end
      kif.i_Next = 1'b0;
      chk({tag, "_vld_drop"}, 128'(kif.o_RKeyVld), 128'd0);
   endtask

   initial begin
      int cyc;
      int bcnt;
      logic [127:0] rk [11];

      rk[0]  = K1;
      rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      for (int i = 0; i < 11; i++) begin
         tbl[i].round = 4'(10 - i);
         tbl[i].rkey  = rk[10 - i];
         tbl[i].last  = (i == 10);
      end
      for (int i = 0; i < 11; i++) begin
         k2_key[i]   = '0;
         k2_known[i] = 1'b0;
      end
      k2_key[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5; k2_known[10] = 1'b1;
      k2_key[9]  = 128'h549932d1f08557681093ed9cbe2c974e; k2_known[9]  = 1'b1;
      k2_key[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe; k2_known[1]  = 1'b1;
      k2_key[0]  = K2;                                    k2_known[0]  = 1'b1;

      rst_n       = 1'b0;
      kif.i_Start = 1'b0;
      kif.i_Key   = '0;
      kif.i_Next  = 1'b0;
      #2;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // K1: latency, busy window, full drain with i_Next held
      start_key(K1);
      wait_vld(1, cyc, bcnt);
      chk("k1_latency", 128'(cyc), 128'd11);
      chk("k1_busy_cycles", 128'(bcnt), 128'd10);
      chk("k1_busy_low_in_output", 128'(kif.o_Busy), 128'd0);
      drain("k1");

      // K2: random i_Next gaps must hold round/key stable
      start_key(K2);
      wait_vld(1, cyc, bcnt);
      chk("k2_latency", 128'(cyc), 128'd11);
      for (int r = 10; r >= 0; r--) begin
         int g;
         g = $urandom_range(0, 2);
         for (int k = 0; k <= g; k++) begin
            chk($sformatf("k2_r%0d_c%0d_round", r, k), 128'(kif.o_Round), 128'(r));
            chk($sformatf("k2_r%0d_c%0d_vld", r, k), 128'(kif.o_RKeyVld), 128'd1);
            if (k2_known[r])
               chk($sformatf("k2_r%0d_c%0d_key", r, k), kif.o_RKey, exp_key(k2_key[r], 4'(r)));
            kif.i_Next = (k == g);
            @(negedge clk);
         end
         kif.i_Next = 1'b0;
      end
      chk("k2_vld_drop", 128'(kif.o_RKeyVld), 128'd0);

      // i_Next while idle is ignored
      kif.i_Next = 1'b1;
      repeat (2) @(negedge clk);
      kif.i_Next = 1'b0;
      chk("idle_next_vld", 128'(kif.o_RKeyVld), 128'd0);
      chk("idle_next_busy", 128'(kif.o_Busy), 128'd0);

      // i_Start during EXPAND is ignored
      start_key(K1);
      repeat (2) @(negedge clk);
      kif.i_Start = 1'b1;
      kif.i_Key   = K2;
      @(negedge clk);
      kif.i_Start = 1'b0;
      wait_vld(4, cyc, bcnt);
      chk("expand_start_latency", 128'(cyc), 128'd11);
      chk("expand_start_key", kif.o_RKey, rk[10]);

      // accept one key, then i_Start+i_Next restarts with K2
      kif.i_Next = 1'b1;
      @(negedge clk);
      chk("pre_restart_round", 128'(kif.o_Round), 128'd9);
      chk("pre_restart_key", kif.o_RKey, exp_key(rk[9], 4'd9));
      kif.i_Start = 1'b1;
      kif.i_Key   = K2;
      @(negedge clk);
      kif.i_Start = 1'b0;
      kif.i_Next  = 1'b0;
      chk("restart_vld_drop", 128'(kif.o_RKeyVld), 128'd0);
      chk("restart_busy", 128'(kif.o_Busy), 128'd1);
      wait_vld(1, cyc, bcnt);
      chk("restart_latency", 128'(cyc), 128'd11);
      chk("restart_round", 128'(kif.o_Round), 128'd10);
      chk("restart_key", kif.o_RKey, k2_key[10]);

      // async reset mid-OUTPUT
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_output");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_vld", 128'(kif.o_RKeyVld), 128'd0);

      // async reset mid-EXPAND, then a clean run
      start_key(K1);
      repeat (3) @(negedge clk);
      chk("mid_expand_busy", 128'(kif.o_Busy), 128'd1);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_expand");
      @(negedge clk);
      rst_n = 1'b1;
      start_key(K1);
      wait_vld(1, cyc, bcnt);
      chk("after_rst_latency", 128'(cyc), 128'd11);
      drain("k1_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/inv_key_sched.md
# inv_key_sched

AES-128 decryption key scheduler: loads the cipher key, runs the forward expansion to round key 10, then emits round keys in reverse order (10 down to 0), one per accepted request, by running the key recurrence backwards. It feeds the decryption round datapath, which consumes InvMixColumns via MixCol_Top with i_fDec=1. No round-key storage array is used: one 128-bit key register plus a round counter.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- i_Clk  input  1  clock; every flop is rising-edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Start  input  1  load i_Key and begin expansion.
- i_Key  input  128  cipher key, byte 0 in [127:120].
- i_Next  input  1  consume the presented round key.
- o_Busy  output  1  high while in EXPAND.
- o_RKeyVld  output  1  o_RKey/o_Round valid.
- o_RKey  output  128  current round key, same byte order as i_Key.
- o_Round  output  4  round index of o_RKey, 10..0.
- o_Last  output  1  o_RKeyVld & (o_Round==0).

## Operation
- States: IDLE, EXPAND, OUTPUT.
- IDLE: i_Start=1 -> key reg <= i_Key, round <= 0, go EXPAND.
- EXPAND: each cycle key reg <= forward next key (w0' = w0^SubWord(RotWord(w3))^Rcon[round+1], wi' = wi^w(i-1)'), round++. When round reaches 10, go OUTPUT.
- OUTPUT: o_RKeyVld=1. On i_Next=1: if round>0, key reg <= previous key, round--; if round==0, go IDLE.
- Previous-key recurrence from (a0..a3) at round r: b3=a3^a2, b2=a2^a1, b1=a1^a0, b0=a0^SubWord(RotWord(b3))^Rcon[r].
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, selected by round counter (no GF division).
- i_Start in OUTPUT: restart with the new key; has priority over a simultaneous i_Next.
- i_Start in EXPAND: ignored.
- i_Next outside OUTPUT: ignored.
- o_Busy=1 only in EXPAND; o_RKeyVld=1 only in OUTPUT.

## Timing
- Reset values: o_Busy=0, o_RKeyVld=0, o_RKey=0, o_Round=0, o_Last=0; state IDLE.
- i_Start sampled at edge t -> EXPAND at edges t+1..t+10 -> o_RKeyVld=1, o_Round=10 in the cycle after edge t+10. Latency is 11 cycles from start edge to first key.
- One key per cycle with i_Next held high. All 11 keys are drained in 11 cycles, and o_RKeyVld drops after the edge accepting round 0.
- o_RKey, o_Round and o_RKeyVld are registered, except the optional InvMixColumns path (see Configuration).
- Reset mid-operation: immediate return to reset values. No partial key survives.

## Configuration
- Macro INV_KEY_EQUIV_EN.
  - Defined: for rounds 1..9, o_RKey = InvMixColumns(raw key) (equivalent inverse cipher form). This path is combinational after the key register, via MixCol_Top instance with i_fDec=1. Rounds 10 and 0 are output raw.
  - Undefined: o_RKey is always the raw key register and MixCol_Top is not instantiated.

## Structure
- Shared package aes_pkg: S-box function/table, Rcon lookup function (round -> byte), state enum constants, NR=10.
- One sub-module: key_subword. It holds four S-box lookups plus RotWord. It is instantiated twice, for the forward and reverse recurrence; sharing one instance via a mux is allowed.

## Test plan
- Reset, then key 2b7e151628aed2a6abf7158809cf4f3c, i_Start pulse -> o_Busy high 10 cycles. On the 11th cycle: o_RKeyVld=1, o_Round=10, o_RKey=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, i_Next held high -> round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e...4f3c with o_Last=1. Valid drops next cycle.
- Key 000102030405060708090a0b0c0d0e0f -> first key 13111d7fe3944a17f307a78b4d2b30c5; random i_Next gaps hold o_RKey/o_Round stable.
- i_Start during EXPAND is ignored (first key unchanged). i_Start with i_Next in OUTPUT restarts: valid drops, new round-10 key appears 11 cycles later.
- i_Rst_n pulsed low mid-EXPAND and mid-OUTPUT -> all outputs 0 asynchronously; a new i_Start then gives the correct sequence.
- With INV_KEY_EQUIV_EN: rounds 10/0 match the raw values above. Rounds 1..9 equal the model's InvMixColumns of the raw keys.
